// File: rtl/lcd_pkg.sv
// lcd_pkg: command encodings, arbiter state encoding and FIFO sizing shared by
// the LCD command arbiter and its FIFOs.
`default_nettype none

package lcd_pkg;

    localparam logic [3:0] WRITE         = 4'd0;
    localparam logic [3:0] CLEAR         = 4'd1;
    localparam logic [3:0] FILL          = 4'd2;
    localparam logic [3:0] SET_WIN       = 4'd3;
    localparam logic [3:0] SET_CURSOR    = 4'd4;
    localparam logic [3:0] ROTATE        = 4'd5;
    localparam logic [3:0] SCROLL        = 4'd6;
    localparam logic [3:0] INVERT        = 4'd7;
    localparam logic [3:0] DISPLAY_ON    = 4'd8;
    localparam logic [3:0] DISPLAY_OFF   = 4'd9;
    localparam logic [3:0] MIRROR_X      = 4'd10;
    localparam logic [3:0] MIRROR_Y      = 4'd11;

    localparam logic [3:0] MAX_LEGAL_CMD = MIRROR_Y;
    localparam int         FIFO_DEPTH    = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISHED  = 3'd4
    } state_t;

    function automatic logic cmd_is_legal(input logic [3:0] cmd);
        return (cmd <= MAX_LEGAL_CMD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: FIFO_DEPTH-entry command FIFO with show-ahead head output.
// Pushes when full and pops when empty are ignored.
`default_nettype none

module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/lcd_cmd_arb.sv
// lcd_cmd_arb: two-source command arbiter feeding an LCD image controller.
// Define LCD_CMD_ARB_FIXED_PRIO_EN for fixed req0 priority instead of round-robin.
`default_nettype none

module lcd_cmd_arb
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [3:0] req0_cmd,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_cmd,
    output logic       req1_ready,
    output logic [3:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic       grant_id,
    output logic       arb_idle,
    output logic       err_illegal,
    output logic [7:0] issued_cnt
);

    state_t     r_state;
    logic [3:0] r_cmd;
    logic       r_cmd_valid;
    logic       r_grant;
    logic       r_err;
    logic [7:0] r_cnt;

    logic       w_acc0, w_acc1;
    logic       w_push0, w_push1;
    logic       w_pop0, w_pop1;
    logic [3:0] w_head0, w_head1;
    logic       w_full0, w_full1;
    logic       w_empty0, w_empty1;
    logic       w_can_issue;
    logic       w_sel;

    assign req0_ready = !w_full0 && (r_state != ST_FINISHED);
    assign req1_ready = !w_full1 && (r_state != ST_FINISHED);
    assign w_acc0     = req0_valid && req0_ready;
    assign w_acc1     = req1_valid && req1_ready;
    assign w_push0    = w_acc0 && cmd_is_legal(req0_cmd);
    assign w_push1    = w_acc1 && cmd_is_legal(req1_cmd);

    assign w_can_issue = (r_state == ST_IDLE) && !lcd_busy && !(w_empty0 && w_empty1);
    assign w_pop0      = w_can_issue && !w_sel;
    assign w_pop1      = w_can_issue && w_sel;

    lcd_cmd_fifo #(.WIDTH(4)) u_fifo0 (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push0),
        .i_data  (req0_cmd),
        .i_pop   (w_pop0),
        .o_data  (w_head0),
        .o_full  (w_full0),
        .o_empty (w_empty0)
    );

    lcd_cmd_fifo #(.WIDTH(4)) u_fifo1 (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push1),
        .i_data  (req1_cmd),
        .i_pop   (w_pop1),
        .o_data  (w_head1),
        .o_full  (w_full1),
        .o_empty (w_empty1)
    );

`ifdef LCD_CMD_ARB_FIXED_PRIO_EN
    assign w_sel = w_empty0;
`else
    // r_rr_ptr names the source preferred when both FIFOs hold commands.
    logic r_rr_ptr;

    always_comb begin
        w_sel = r_rr_ptr;
        if (w_empty0) begin
            w_sel = 1'b1;
        end else if (w_empty1) begin
            w_sel = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_can_issue) begin
            r_rr_ptr <= ~w_sel;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_acc0 && !cmd_is_legal(req0_cmd)) ||
                     (w_acc1 && !cmd_is_legal(req1_cmd));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_grant     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_can_issue) begin
                        r_cmd       <= w_sel ? w_head1 : w_head0;
                        r_grant     <= w_sel;
                        r_cmd_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (lcd_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // A WRITE ends the session: only lcd_done releases it.
                    if (r_cmd == WRITE) begin
                        if (lcd_done) begin
                            r_state <= ST_FINISHED;
                        end
                    end else if (!lcd_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FINISHED: begin
                    r_state <= ST_FINISHED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign lcd_cmd       = r_cmd;
    assign lcd_cmd_valid = r_cmd_valid;
    assign grant_id      = r_grant;
    assign err_illegal   = r_err;
    assign issued_cnt    = r_cnt;
    assign arb_idle      = (r_state == ST_IDLE) && w_empty0 && w_empty1;

endmodule

`default_nettype wire

// File: doc/lcd_cmd_arb.md
LCD_CMD_ARB -- requirements
Module: lcd_cmd_arb

Interface
REQ-001 SHALL have a clock port: clk, input, 1 bit, rising-edge clock.
REQ-002 SHALL have a reset port: reset, input, 1 bit, asynchronous, active-high.
REQ-003 SHALL have req0_valid, req0_cmd, req0_ready as input 1, input 4, output 1: host command push (valid/ready).
REQ-004 SHALL have req1_valid, req1_cmd, req1_ready as input 1, input 4, output 1: script-engine command push (valid/ready).
REQ-005 SHALL have lcd_cmd, output, 4 bits: command to the image controller, held stable from issue until the controller's busy falls.
REQ-006 SHALL have lcd_cmd_valid, output, 1 bit: single-cycle issue strobe.
REQ-007 SHALL have lcd_busy, input, 1 bit: controller busy flag.
REQ-008 SHALL have lcd_done, input, 1 bit: controller write-out complete.
REQ-009 SHALL have grant_id, output, 1 bit: source of the command currently in flight.
REQ-010 SHALL have arb_idle, output, 1 bit: high when no command is in flight and both FIFOs are empty.
REQ-011 SHALL have err_illegal, output, 1 bit: one-cycle pulse on a rejected command.
REQ-012 SHALL have issued_cnt, output, 8 bits: count of commands issued, saturating at 255.

Function
REQ-013 SHALL give each requester a 4-entry FIFO; reqN_ready = FIFO not full and state != FINISHED.
REQ-014 SHALL, on accepted push with cmd > 11, drop the command and pulse err_illegal the next cycle; FIFO unchanged.
REQ-015 SHALL, on push to a full FIFO, not modify contents; the push is simply not accepted.
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, FINISHED.
REQ-017 IDLE: when lcd_busy=0 and any FIFO non-empty, select a source, pop its head into lcd_cmd, set grant_id, go to ISSUE.
REQ-018 ISSUE: lcd_cmd_valid=1 for exactly this cycle; increment issued_cnt; go to WAIT_ACK.
REQ-019 WAIT_ACK: on lcd_busy=1 go to WAIT_DONE; otherwise remain (no timeout).
REQ-020 WAIT_DONE: cmd 0 waits for lcd_done=1, then goes to FINISHED; any other cmd waits for lcd_busy=0, then goes to IDLE.
REQ-021 FINISHED: terminal until reset; both ready low; FIFO contents retained but never issued.
REQ-022 Arbitration SHALL be round-robin: when both FIFOs are non-empty, grant the source not granted last; first grant after reset goes to req0.
REQ-023 Simultaneous push and pop on the same FIFO SHALL be legal when not full, with occupancy unchanged.
REQ-024 Issue-to-issue spacing SHALL be at least 3 cycles: ISSUE, at least one cycle of WAIT_ACK, and one cycle of WAIT_DONE.

Reset
REQ-025 Reset SHALL force state IDLE, both FIFOs empty, lcd_cmd=0, lcd_cmd_valid=0, grant_id=0, err_illegal=0, issued_cnt=0, and the round-robin pointer to req0.
REQ-026 Reset asserted mid-command SHALL abort it immediately; arb_idle=1 on the first cycle after release.

Configuration
REQ-027 SHALL, with LCD_CMD_ARB_FIXED_PRIO_EN defined, replace round-robin with fixed priority: req0 always wins when both FIFOs are non-empty.
REQ-028 SHALL, without LCD_CMD_ARB_FIXED_PRIO_EN, use round-robin per REQ-022.

Structure
REQ-029 SHALL place in package lcd_pkg: the 4-bit command encoding constants (WRITE=0 ... MIRROR_Y=11), the state enum, FIFO depth 4, and max legal cmd 11.
REQ-030 SHALL instantiate sub-module lcd_cmd_fifo (4 entries, 4 bits wide, push/pop/full/empty) twice.

Verification
REQ-031 Both FIFOs preloaded with cmds 1 and 2; controller model idle -> lcd_cmd order 1(g0), 2(g1), with lcd_cmd_valid 1-cycle pulses.
REQ-032 req0 pushes 12 -> err_illegal pulses once, req0 FIFO stays empty, issued_cnt stays 0.
REQ-033 req0 pushes 5 with lcd_busy held 1 -> no issue; after lcd_busy drops -> ISSUE; lcd_cmd=5 held until busy falls.
REQ-034 Push cmd 0 then cmd 3 -> cmd 0 issued; after lcd_done=1 state FINISHED, req0_ready=0, and cmd 3 is never issued.
REQ-035 Five pushes to req1 while blocked -> the 5th is not accepted (req1_ready=0); drain yields exactly four issues.
REQ-036 Reset pulsed during WAIT_DONE -> next cycle lcd_cmd_valid=0, arb_idle=1, issued_cnt=0.
